motor_pwm_driver: RTL and testbench
===================================

// Module: motor_pwm_driver
// PURPOSE
//  H-bridge driver for the robot's two DC motors (4 control pins).
//  Adds PWM speed control, a valid/ready command interface and enforced dead-time (all pins low) on direction reversal.
//  Sits between the SoC control register and the motor driver pins.
//  Keeps the existing estado encoding: PAUSA=0, RETROCESO=1, AVANCE=2, GIROD=3, GIROI=4.
// PARAMETERS
//  PWM_BITS     8    duty / PWM counter width
//  PRESCALE     100  clk cycles per PWM counter step (>=1)
//  DEAD_CYCLES  50   clk cycles pins are forced to 4'b0000 on reversal (>=1)
// PORTS
//  clk        in   1         system clock; single clock domain
//  rst        in   1         synchronous, active-high reset
//  cmd_valid  in   1         command present on estado/duty
//  cmd_ready  out  1         block can accept a command
//  estado     in   3         requested motion: 0..4 as above; 5..7 treated as PAUSA
//  duty       in   PWM_BITS  requested duty; 0 = off, all-ones = 100%
//  pin        out  4         H-bridge inputs, registered
//  busy       out  1         high while in dead-time
// BEHAVIOUR
//  - Reset (rst high at posedge): pin=4'b0000, busy=0, cmd_ready=0 during rst.
//    Internal estado_r=PAUSA, duty_r=duty_sh=0, prescaler=0, pwm_cnt=0, FSM=S_RUN.
//    cmd_ready=1 from the first cycle after rst is released.
//  - Pattern map: AVANCE 0110, RETROCESO 1001, GIROD 0101, GIROI 1010, PAUSA/other 0000.
//  - Prescaler: counts 0..PRESCALE-1 and wraps. tick = (prescaler==PRESCALE-1).
//    pwm_cnt increments on tick and wraps 2^PWM_BITS-1 -> 0. "wrap" is a tick with pwm_cnt at max.
//  - pwm_on = (duty_r=={PWM_BITS{1'b1}}) | (pwm_cnt < duty_r).
//  - pin <= (FSM==S_RUN && pwm_on) ? pattern(estado_r) : 4'b0000. One clk of latency from internal state.
//  - Handshake: accept = cmd_valid & cmd_ready. cmd_ready = (FSM==S_RUN) & ~rst.
//    estado/duty are sampled only on accept.
//  - FSM S_RUN, on accept (estado normalised: 5..7 -> 0):
//    a) new estado == estado_r: duty_sh<=duty. duty_r<=duty_sh at the next wrap.
//       No glitch mid-period; if several commands arrive before a wrap, the last one wins.
//    b) new estado != estado_r, and either new estado or estado_r is PAUSA:
//       estado_r<=new, duty_r<=duty_sh<=duty, prescaler and pwm_cnt cleared.
//       The new pattern is visible at accept edge +1.
//    c) new estado != estado_r, and both are non-PAUSA:
//       latch new estado/duty into pending registers, dead counter <= DEAD_CYCLES-1, FSM->S_DEAD.
//  - FSM S_DEAD: busy=1, cmd_ready=0, pin=0000. Dead counter decrements every clk.
//    At 0: estado_r/duty_r/duty_sh <= pending, PWM counters cleared, FSM->S_RUN.
//    pin is 0000 for exactly DEAD_CYCLES cycles after the accept edge; the new pattern is visible on the next cycle.
//  - rst during S_DEAD aborts the dead-time. The pending command is discarded and the block returns to PAUSA.
//  - Simultaneous accept and wrap: the case (a) write to duty_sh wins; duty_r takes the old duty_sh at that wrap.
// TESTING (bench params PWM_BITS=4, PRESCALE=4, DEAD_CYCLES=6)
//  1. rst high 3 clk, then low -> pin=0000, busy=0 throughout; cmd_ready 0 during rst, 1 after.
//  2. accept estado=2, duty=15 -> pin=0110 from next clk, constant.
//     duty=8 -> 0110 for 32 clk, then 0000 for 32 clk, period 64.
//  3. in AVANCE duty=8, accept estado=1 duty=4 -> cmd_ready=0 and busy=1 for 6 clk, pin=0000 for 6 clk.
//     Then pin=1001 high 16 of every 64 clk.
//  4. in AVANCE duty=8, accept estado=2 duty=12 mid-period -> high time stays 32 clk until the wrap, then 48 clk.
//  5. accept estado=6 duty=15 -> pin=0000; a following estado=3 is immediate (no dead-time): pin=0101 next clk.
//  6. assert rst in cycle 3 of dead-time -> pin=0000, busy=0 next clk; no pending pattern appears afterwards.

Source files
------------

// File: rtl/motor_pwm_driver.sv
// H-bridge driver for two DC motors: PWM speed control, valid/ready command
// interface and a forced all-low dead-time whenever the motion reverses.
module motor_pwm_driver #(
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 100,
  parameter int DEAD_CYCLES = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          estado,
  input  logic [PWM_BITS-1:0] duty,
  output logic [3:0]          pin,
  output logic                busy
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DC_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [2:0] PAUSA     = 3'd0;
  localparam logic [2:0] RETROCESO = 3'd1;
  localparam logic [2:0] AVANCE    = 3'd2;
  localparam logic [2:0] GIROD     = 3'd3;
  localparam logic [2:0] GIROI     = 3'd4;

  typedef enum logic {S_RUN, S_DEAD} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          estado_reg, pend_estado_reg;
  logic [PWM_BITS-1:0] duty_reg, duty_sh_reg, pend_duty_reg;
  logic [PS_W-1:0]     prescaler_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [DC_W-1:0]     dead_cnt_reg;
  logic [3:0]          pin_reg;

  logic       accept, tick, wrap, pwm_on, dead_done;
  logic       case_a, case_b, case_c;
  logic [2:0] estado_norm;

  function automatic logic [3:0] pattern(input logic [2:0] e);
    case (e)
      AVANCE:    pattern = 4'b0110;
      RETROCESO: pattern = 4'b1001;
      GIROD:     pattern = 4'b0101;
      GIROI:     pattern = 4'b1010;
      default:   pattern = 4'b0000;
    endcase
  endfunction

  assign cmd_ready   = (state_reg == S_RUN) & ~rst;
  assign busy        = (state_reg == S_DEAD);
  assign accept      = cmd_valid & cmd_ready;
  assign estado_norm = (estado > GIROI) ? PAUSA : estado;
  assign tick        = (prescaler_reg == PS_W'(PRESCALE - 1));
  assign wrap        = tick & (pwm_cnt_reg == {PWM_BITS{1'b1}});
  assign pwm_on      = (duty_reg == {PWM_BITS{1'b1}}) | (pwm_cnt_reg < duty_reg);
  assign dead_done   = (state_reg == S_DEAD) && (dead_cnt_reg == '0);
  assign pin         = pin_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_RUN;
    else     state_reg <= state_next;
  end

  // Reversal between two driven directions needs dead-time; anything via PAUSA is immediate.
  always_comb begin
    state_next = state_reg;
    case_a     = 1'b0;
    case_b     = 1'b0;
    case_c     = 1'b0;
    if (accept) begin
      if (estado_norm == estado_reg)
        case_a = 1'b1;
      else if ((estado_norm == PAUSA) || (estado_reg == PAUSA))
        case_b = 1'b1;
      else
        case_c = 1'b1;
    end
    if (case_c)    state_next = S_DEAD;
    if (dead_done) state_next = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_reg      <= PAUSA;
      duty_reg        <= '0;
      duty_sh_reg     <= '0;
      pend_estado_reg <= PAUSA;
      pend_duty_reg   <= '0;
      prescaler_reg   <= '0;
      pwm_cnt_reg     <= '0;
      dead_cnt_reg    <= '0;
      pin_reg         <= 4'b0000;
    end else begin
      if (case_b || dead_done) begin
        prescaler_reg <= '0;
        pwm_cnt_reg   <= '0;
      end else begin
        prescaler_reg <= tick ? '0 : prescaler_reg + PS_W'(1);
        if (tick) pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
      end

      // Shadowed duty only takes effect at a period boundary; a same-edge write to the shadow wins.
      if (wrap)   duty_reg    <= duty_sh_reg;
      if (case_a) duty_sh_reg <= duty;

      if (case_b) begin
        estado_reg  <= estado_norm;
        duty_reg    <= duty;
        duty_sh_reg <= duty;
      end

      if (case_c) begin
        pend_estado_reg <= estado_norm;
        pend_duty_reg   <= duty;
        dead_cnt_reg    <= DC_W'(DEAD_CYCLES - 1);
      end else if ((state_reg == S_DEAD) && (dead_cnt_reg != '0)) begin
        dead_cnt_reg <= dead_cnt_reg - DC_W'(1);
      end

      if (dead_done) begin
        estado_reg  <= pend_estado_reg;
        duty_reg    <= pend_duty_reg;
        duty_sh_reg <= pend_duty_reg;
      end

      pin_reg <= ((state_reg == S_RUN) && pwm_on) ? pattern(estado_reg) : 4'b0000;
    end
  end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver: stimulus queues the expected
// {pin,busy,cmd_ready} for every cycle, a monitor pops and compares each cycle.
module tb_motor_pwm_driver;

  localparam int PWM_BITS    = 4;
  localparam int PRESCALE    = 4;
  localparam int DEAD_CYCLES = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [2:0]          estado = 3'd0;
  logic [PWM_BITS-1:0] duty = '0;
  logic [3:0]          pin;
  logic                busy;

  typedef struct packed {
    logic [3:0] pin;
    logic       busy;
    logic       ready;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  string phase = "reset";

  motor_pwm_driver #(
    .PWM_BITS   (PWM_BITS),
    .PRESCALE   (PRESCALE),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .estado   (estado),
    .duty     (duty),
    .pin      (pin),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Monitor: one expected entry per cycle, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks = checks + 1;
        if ({pin, busy, cmd_ready} !== e) begin
          failures = failures + 1;
          $display("FAIL %s cyc=%0d pin/busy/ready got=%b/%b/%b exp=%b/%b/%b",
                   phase, cyc, pin, busy, cmd_ready, e.pin, e.busy, e.ready);
        end
      end
    end
  end

  task automatic step(input logic [3:0] p, input logic b, input logic r);
    exp_q.push_back({p, b, r});
    @(posedge clk);
    #1;
  endtask

  task automatic pwm(input logic [3:0] pat, input int high, input int total);
    for (int i = 0; i < total; i++)
      step((i < high) ? pat : 4'b0000, 1'b0, 1'b1);
  endtask

  task automatic issue(input logic [2:0] e, input logic [PWM_BITS-1:0] d, input logic [3:0] cur);
    estado    = e;
    duty      = d;
    cmd_valid = 1'b1;
    $display("cmd cyc=%0d phase=%s estado=%0d duty=%0d", cyc, phase, e, d);
    step(cur, 1'b0, 1'b1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    // 1. reset held for three clocks
    @(posedge clk);
    #1;
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    // 2. full duty, then duty 8 entered through PAUSA
    phase = "avance_full";
    issue(3'd2, 4'd15, 4'b0000);
    step(4'b0000, 1'b0, 1'b1);
    pwm(4'b0110, 20, 20);
    phase = "to_pausa";
    issue(3'd0, 4'd0, 4'b0110);
    step(4'b0110, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    phase = "avance_half";
    issue(3'd2, 4'd8, 4'b0000);
    step(4'b0000, 1'b0, 1'b1);
    pwm(4'b0110, 32, 64);
    pwm(4'b0110, 32, 64);

    // 3. reversal AVANCE -> RETROCESO with dead-time
    phase = "reversal";
    pwm(4'b0110, 5, 5);
    issue(3'd1, 4'd4, 4'b0110);
    step(4'b0110, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    phase = "retroceso_q";
    pwm(4'b1001, 16, 64);
    pwm(4'b1001, 16, 64);

    // 4. duty change mid-period is deferred to the wrap
    phase = "to_pausa2";
    issue(3'd0, 4'd0, 4'b1001);
    step(4'b1001, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    phase = "avance_half2";
    issue(3'd2, 4'd8, 4'b0000);
    step(4'b0000, 1'b0, 1'b1);
    pwm(4'b0110, 10, 10);
    phase = "duty_shadow";
    issue(3'd2, 4'd12, 4'b0110);
    pwm(4'b0110, 21, 21);
    pwm(4'b0110, 0, 32);
    phase = "duty_applied";
    pwm(4'b0110, 48, 64);
    pwm(4'b0110, 48, 64);

    // 5. out-of-range estado acts as PAUSA; leaving PAUSA is immediate
    phase = "estado6";
    issue(3'd6, 4'd15, 4'b0110);
    step(4'b0110, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b1);
    phase = "girod";
    issue(3'd3, 4'd5, 4'b0000);
    step(4'b0000, 1'b0, 1'b1);
    pwm(4'b0101, 20, 64);

    // 6. reset during dead-time discards the pending command
    phase = "dead_abort";
    issue(3'd4, 4'd15, 4'b0101);
    step(4'b0101, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    rst = 1'b1;
    step(4'b0000, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step(4'b0000, 1'b0, 1'b1);
    phase = "after_abort";
    issue(3'd1, 4'd15, 4'b0000);
    step(4'b0000, 1'b0, 1'b1);
    pwm(4'b1001, 5, 5);

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain queue_left got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
